// File: rtl/fish_renderer.sv
// Fish sprite addressing and colour stage: maps display counters to sprite ROM row/col,
// realigns the ROM colour with the pixel stream, keys transparency and applies frame-end updates.
module fish_renderer #(
    parameter int unsigned SCALE_LOG2  = 1,
    parameter logic [9:0]  H_LAST      = 10'd799,
    parameter logic [9:0]  V_LAST      = 10'd524,
    parameter logic [9:0]  INIT_X      = 10'd300,
    parameter logic [9:0]  INIT_Y      = 10'd200,
    parameter logic [11:0] TRANSPARENT = 12'h000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        bright_i,
    input  logic [9:0]  hcount_i,
    input  logic [9:0]  vcount_i,
    input  logic [11:0] bg_rgb_i,
    input  logic        pos_wr_i,
    input  logic [9:0]  new_x_i,
    input  logic [9:0]  new_y_i,
    input  logic        new_flip_i,
    input  logic [11:0] color_data_i,
    output logic [2:0]  row_o,
    output logic [3:0]  col_o,
    output logic [11:0] rgb_o,
    output logic        frame_tick_o,
    output logic        pending_o
);

    localparam logic [10:0] BoxW = 11'(15 << SCALE_LOG2);
    localparam logic [10:0] BoxH = 11'(8 << SCALE_LOG2);

    logic [9:0]  act_x_q, act_x_d, act_y_q, act_y_d, pend_x_q, pend_x_d, pend_y_q, pend_y_d;
    logic        act_flip_q, act_flip_d, pend_flip_q, pend_flip_d, pending_q, pending_d;
    logic        frame_tick_q, frame_end;
    logic [2:0]  row_q, row_d;
    logic [3:0]  col_q, col_d, col_raw;
    logic        in_box_q, in_box_q2, in_box, bright_q, bright_q2;
    logic [11:0] bg_q, bg_q2, rgb_q, rgb_d;
    logic [10:0] h_ext, v_ext, ax_ext, ay_ext, dx, dy;

    assign frame_end = (hcount_i == H_LAST) && (vcount_i == V_LAST);

    // 11-bit compare keeps a box near the right/bottom edge from wrapping to column 0
    always_comb begin
        h_ext   = {1'b0, hcount_i};
        v_ext   = {1'b0, vcount_i};
        ax_ext  = {1'b0, act_x_q};
        ay_ext  = {1'b0, act_y_q};
        dx      = h_ext - ax_ext;
        dy      = v_ext - ay_ext;
        in_box  = (h_ext >= ax_ext) && (h_ext < ax_ext + BoxW) &&
                  (v_ext >= ay_ext) && (v_ext < ay_ext + BoxH);
        col_raw = 4'(dx >> SCALE_LOG2);
        row_d   = 3'd0;
        col_d   = 4'd0;
        if (in_box) begin
            row_d = 3'(dy >> SCALE_LOG2);
            col_d = act_flip_q ? 4'd14 - col_raw : col_raw;
        end
    end

    always_comb begin
        act_x_d     = act_x_q;
        act_y_d     = act_y_q;
        act_flip_d  = act_flip_q;
        pend_x_d    = pend_x_q;
        pend_y_d    = pend_y_q;
        pend_flip_d = pend_flip_q;
        pending_d   = pending_q;
        if (frame_end) begin
            pending_d = 1'b0;
            if (pos_wr_i) begin
                act_x_d    = new_x_i;
                act_y_d    = new_y_i;
                act_flip_d = new_flip_i;
            end else if (pending_q) begin
                act_x_d    = pend_x_q;
                act_y_d    = pend_y_q;
                act_flip_d = pend_flip_q;
            end
        end else if (pos_wr_i) begin
            pend_x_d    = new_x_i;
            pend_y_d    = new_y_i;
            pend_flip_d = new_flip_i;
            pending_d   = 1'b1;
        end
    end

    // color_data_i lines up with the second delay stage
    always_comb begin
        rgb_d = bg_q2;
        if (!bright_q2) begin
            rgb_d = 12'h000;
        end else if (in_box_q2 && (color_data_i != TRANSPARENT)) begin
            rgb_d = color_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            act_x_q      <= INIT_X;
            act_y_q      <= INIT_Y;
            act_flip_q   <= 1'b0;
            pend_x_q     <= 10'd0;
            pend_y_q     <= 10'd0;
            pend_flip_q  <= 1'b0;
            pending_q    <= 1'b0;
            frame_tick_q <= 1'b0;
            row_q        <= 3'd0;
            col_q        <= 4'd0;
            in_box_q     <= 1'b0;
            in_box_q2    <= 1'b0;
            bright_q     <= 1'b0;
            bright_q2    <= 1'b0;
            bg_q         <= 12'h000;
            bg_q2        <= 12'h000;
            rgb_q        <= 12'h000;
        end else begin
            act_x_q      <= act_x_d;
            act_y_q      <= act_y_d;
            act_flip_q   <= act_flip_d;
            pend_x_q     <= pend_x_d;
            pend_y_q     <= pend_y_d;
            pend_flip_q  <= pend_flip_d;
            pending_q    <= pending_d;
            frame_tick_q <= frame_end;
            row_q        <= row_d;
            col_q        <= col_d;
            in_box_q     <= in_box;
            in_box_q2    <= in_box_q;
            bright_q     <= bright_i;
            bright_q2    <= bright_q;
            bg_q         <= bg_rgb_i;
            bg_q2        <= bg_q;
            rgb_q        <= rgb_d;
        end
    end

    assign row_o        = row_q;
    assign col_o        = col_q;
    assign rgb_o        = rgb_q;
    assign frame_tick_o = frame_tick_q;
    assign pending_o    = pending_q;

endmodule

// File: tb/tb_fish_renderer.sv
// Bench for fish_renderer: sprite ROM stand-in, arithmetic reference model checked every
// cycle, and directed probes with literal expected values.
module tb_fish_renderer;

    localparam int SC = 2;   // 2^SCALE_LOG2 with SCALE_LOG2 = 1

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bright = 1'b0;
    logic [9:0]  hcount = 10'd0;
    logic [9:0]  vcount = 10'd0;
    logic [11:0] bg_rgb = 12'h000;
    logic        pos_wr = 1'b0;
    logic [9:0]  new_x = 10'd0;
    logic [9:0]  new_y = 10'd0;
    logic        new_flip = 1'b0;
    logic [11:0] color_data = 12'h000;
    logic [2:0]  row;
    logic [3:0]  col;
    logic [11:0] rgb;
    logic        frame_tick, pending;

    int tests = 0;
    int failed = 0;

    fish_renderer #(
        .SCALE_LOG2(1), .H_LAST(10'd799), .V_LAST(10'd524),
        .INIT_X(10'd300), .INIT_Y(10'd200), .TRANSPARENT(12'h000)
    ) dut (
        .clk_i(clk), .rst_i(rst), .bright_i(bright), .hcount_i(hcount), .vcount_i(vcount),
        .bg_rgb_i(bg_rgb), .pos_wr_i(pos_wr), .new_x_i(new_x), .new_y_i(new_y),
        .new_flip_i(new_flip), .color_data_i(color_data), .row_o(row), .col_o(col),
        .rgb_o(rgb), .frame_tick_o(frame_tick), .pending_o(pending)
    );

    always #5 clk = ~clk;

    // Sprite content: only (row 4, col 4) is transparent
    function automatic logic [11:0] rom_val(int r, int c);
        logic [3:0] a, b;
        if (r == 4 && c == 4) return 12'h000;
        a = 4'(r + 8);
        b = 4'(c + 3);
        return {a, b, a};
    endfunction

    always @(posedge clk) color_data <= rom_val(int'(row), int'(col));

    function automatic bit f_inbox(int h, int v, int ax, int ay);
        return h >= ax && h < ax + 15 * SC && v >= ay && v < ay + 8 * SC;
    endfunction

    function automatic int f_row(int h, int v, int ax, int ay);
        return f_inbox(h, v, ax, ay) ? (v - ay) / SC : 0;
    endfunction

    function automatic int f_col(int h, int v, int ax, int ay, bit flip);
        if (!f_inbox(h, v, ax, ay)) return 0;
        return flip ? 14 - (h - ax) / SC : (h - ax) / SC;
    endfunction

    function automatic logic [11:0] f_pix(int h, int v, int ax, int ay, bit flip, bit br,
                                          logic [11:0] bg);
        logic [11:0] c;
        if (!br) return 12'h000;
        c = rom_val(f_row(h, v, ax, ay), f_col(h, v, ax, ay, flip));
        if (f_inbox(h, v, ax, ay) && c != 12'h000) return c;
        return bg;
    endfunction

    // Reference model
    logic [2:0]  m_row;
    logic [3:0]  m_col;
    logic [11:0] m_rgb1, m_rgb2, m_rgb3;
    logic        m_tick, m_pend, m_af, m_pf;
    logic [9:0]  m_ax, m_ay, m_px, m_py;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_row <= 3'd0; m_col <= 4'd0;
            m_rgb1 <= 12'h000; m_rgb2 <= 12'h000; m_rgb3 <= 12'h000;
            m_tick <= 1'b0; m_pend <= 1'b0;
            m_ax <= 10'd300; m_ay <= 10'd200; m_af <= 1'b0;
            m_px <= 10'd0; m_py <= 10'd0; m_pf <= 1'b0;
        end else begin
            m_row  <= 3'(f_row(int'(hcount), int'(vcount), int'(m_ax), int'(m_ay)));
            m_col  <= 4'(f_col(int'(hcount), int'(vcount), int'(m_ax), int'(m_ay), m_af));
            m_rgb1 <= f_pix(int'(hcount), int'(vcount), int'(m_ax), int'(m_ay), m_af,
                            bright, bg_rgb);
            m_rgb2 <= m_rgb1;
            m_rgb3 <= m_rgb2;
            m_tick <= (hcount == 10'd799 && vcount == 10'd524);
            if (hcount == 10'd799 && vcount == 10'd524) begin
                m_pend <= 1'b0;
                if (pos_wr) begin
                    m_ax <= new_x; m_ay <= new_y; m_af <= new_flip;
                end else if (m_pend) begin
                    m_ax <= m_px; m_ay <= m_py; m_af <= m_pf;
                end
            end else if (pos_wr) begin
                m_px <= new_x; m_py <= new_y; m_pf <= new_flip; m_pend <= 1'b1;
            end
        end
    end

    task automatic check(string name, logic [11:0] act, logic [11:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("model_row", 12'(row), 12'(m_row));
        check("model_col", 12'(col), 12'(m_col));
        check("model_rgb", rgb, m_rgb3);
        check("model_tick", 12'(frame_tick), 12'(m_tick));
        check("model_pending", 12'(pending), 12'(m_pend));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold one pixel: row/col after one edge, rgb after three
    task automatic probe(string nm, int h, int v, bit br, logic [11:0] bg,
                         int er, int ec, logic [11:0] ergb);
        hcount = 10'(h); vcount = 10'(v); bright = br; bg_rgb = bg; pos_wr = 1'b0;
        tick();
        check({nm, "_row"}, 12'(row), 12'(er));
        check({nm, "_col"}, 12'(col), 12'(ec));
        tick();
        tick();
        check({nm, "_rgb"}, rgb, ergb);
    endtask

    task automatic write_pos(int x, int y, bit f);
        hcount = 10'd10; vcount = 10'd10; bright = 1'b1;
        pos_wr = 1'b1; new_x = 10'(x); new_y = 10'(y); new_flip = f;
        tick();
        pos_wr = 1'b0;
        check("wr_pending", 12'(pending), 12'd1);
    endtask

    task automatic frame_end(bit wr, int x, int y, bit f);
        hcount = 10'd799; vcount = 10'd524; bright = 1'b0;
        pos_wr = wr; new_x = 10'(x); new_y = 10'(y); new_flip = f;
        tick();
        pos_wr = 1'b0; hcount = 10'd0; vcount = 10'd0;
        check("fe_tick_hi", 12'(frame_tick), 12'd1);
        check("fe_pending_clr", 12'(pending), 12'd0);
        tick();
        check("fe_tick_lo", 12'(frame_tick), 12'd0);
    endtask

    initial begin
        repeat (3) tick();
        check("rst_rgb", rgb, 12'h000);
        check("rst_pending", 12'(pending), 12'd0);
        rst = 1'b0;
        tick();

        probe("base", 308, 206, 1'b1, 12'h123, 3, 4, 12'hB7B);
        probe("transp", 308, 208, 1'b1, 12'h00F, 4, 4, 12'h00F);
        probe("left_out", 299, 206, 1'b1, 12'h0A5, 0, 0, 12'h0A5);

        frame_end(1'b1, 300, 200, 1'b1);
        probe("flip_mid", 308, 206, 1'b1, 12'h111, 3, 10, 12'hBDB);
        probe("flip_edge", 300, 200, 1'b1, 12'h111, 0, 14, 12'h818);

        write_pos(100, 200, 1'b0);
        probe("held_flip", 308, 206, 1'b1, 12'h222, 3, 10, 12'hBDB);
        check("still_pending", 12'(pending), 12'd1);
        frame_end(1'b0, 0, 0, 1'b0);
        probe("moved_100", 108, 206, 1'b1, 12'h222, 3, 4, 12'hB7B);

        write_pos(50, 200, 1'b0);
        write_pos(60, 200, 1'b0);
        frame_end(1'b0, 0, 0, 1'b0);
        probe("last_wins", 64, 206, 1'b1, 12'h333, 3, 2, 12'hB5B);

        frame_end(1'b1, 70, 200, 1'b0);
        probe("fe_write", 78, 206, 1'b1, 12'h333, 3, 4, 12'hB7B);

        frame_end(1'b1, 1020, 200, 1'b0);
        probe("no_wrap", 1023, 206, 1'b1, 12'h444, 3, 1, 12'hB4B);
        probe("wrap_out", 2, 206, 1'b1, 12'h456, 0, 0, 12'h456);
        probe("blank", 1023, 206, 1'b0, 12'hFFF, 3, 1, 12'h000);

        write_pos(500, 200, 1'b0);
        hcount = 10'd1023; vcount = 10'd206; bright = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("mid_rst_row", 12'(row), 12'd0);
        check("mid_rst_col", 12'(col), 12'd0);
        check("mid_rst_rgb", rgb, 12'h000);
        check("mid_rst_pending", 12'(pending), 12'd0);
        tick();
        rst = 1'b0;
        frame_end(1'b0, 0, 0, 1'b0);
        probe("after_rst", 308, 206, 1'b1, 12'h555, 3, 4, 12'hB7B);

        tick();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
